// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 responder oversampled on the system clock
// Define SPI_SLAVE_RESPONDER_LSB_FIRST_EN to transfer words LSB first instead of MSB first.
module spi_slave_responder #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             spi_sclk_i,
   input  logic             spi_cs_n_i,
   input  logic             spi_mosi_i,
   output logic             spi_miso_o,
   input  logic [WIDTH-1:0] tx_data_i,
   input  logic             tx_valid_i,
   output logic             tx_ready_o,
   output logic [WIDTH-1:0] rx_data_o,
   output logic             rx_valid_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [SYNC_STAGES:0]   sclk_sync;
   logic [SYNC_STAGES:0]   cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;

   logic [0:0]       state, state_nxt;
   logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0] rx_shift, rx_shift_nxt;
   logic [WIDTH-1:0] tx_shift, tx_shift_nxt;
   logic [WIDTH-1:0] hold_data, hold_data_nxt;
   logic [WIDTH-1:0] rx_data_nxt;
   logic [WIDTH-1:0] rx_shifted, tx_shifted;
   logic             hold_full, hold_full_nxt;
   logic             rx_valid_nxt;
   logic             tx_reload;
   logic             miso_bit;
   logic             sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

   // Edges come from the newest synchronised flop against its history flop.
   assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
   assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES];
   assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES];
   assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

`ifdef SPI_SLAVE_RESPONDER_LSB_FIRST_EN
   assign rx_shifted = {mosi_bit, rx_shift[WIDTH-1:1]};
   assign tx_shifted = {1'b0, tx_shift[WIDTH-1:1]};
   assign miso_bit   = tx_shift_nxt[0];
`else
   assign rx_shifted = {rx_shift[WIDTH-2:0], mosi_bit};
   assign tx_shifted = {tx_shift[WIDTH-2:0], 1'b0};
   assign miso_bit   = tx_shift_nxt[WIDTH-1];
`endif

   assign tx_ready_o = ~hold_full;
   assign busy_o     = (state == ST_ACTIVE);

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      rx_shift_nxt  = rx_shift;
      tx_shift_nxt  = tx_shift;
      rx_data_nxt   = rx_data_o;
      rx_valid_nxt  = 1'b0;
      tx_reload     = 1'b0;
      hold_data_nxt = hold_data;
      hold_full_nxt = hold_full;

      // A CS edge takes priority over any SCLK edge seen in the same cycle.
      if (cs_fall) begin
         state_nxt    = ST_ACTIVE;
         bit_cnt_nxt  = '0;
         rx_shift_nxt = '0;
         tx_reload    = 1'b1;
      end else if (cs_rise) begin
         state_nxt    = ST_IDLE;
         bit_cnt_nxt  = '0;
         rx_shift_nxt = '0;
         tx_shift_nxt = '0;
      end else if (state == ST_ACTIVE) begin
         if (sclk_rise) begin
            rx_shift_nxt = rx_shifted;
            if (bit_cnt == CW'(WIDTH - 1)) begin
               bit_cnt_nxt  = '0;
               rx_data_nxt  = rx_shifted;
               rx_valid_nxt = 1'b1;
               tx_reload    = 1'b1;
            end else begin
               bit_cnt_nxt = bit_cnt + CW'(1);
            end
         end else if (sclk_fall && (bit_cnt != '0)) begin
            tx_shift_nxt = tx_shifted;
         end
      end

      if (tx_reload) begin
         tx_shift_nxt = hold_full ? hold_data : '0;
      end

      // A load can only happen while empty, so a same-cycle reload sees zeros.
      if (tx_valid_i && !hold_full) begin
         hold_data_nxt = tx_data_i;
         hold_full_nxt = 1'b1;
      end else if (tx_reload) begin
         hold_full_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         sclk_sync  <= '0;
         cs_sync    <= '1;
         mosi_sync  <= '0;
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         hold_data  <= '0;
         hold_full  <= 1'b0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         spi_miso_o <= 1'b0;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC_STAGES-1:0], spi_sclk_i};
         cs_sync    <= {cs_sync[SYNC_STAGES-1:0], spi_cs_n_i};
         mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         rx_shift   <= rx_shift_nxt;
         tx_shift   <= tx_shift_nxt;
         hold_data  <= hold_data_nxt;
         hold_full  <= hold_full_nxt;
         rx_data_o  <= rx_data_nxt;
         rx_valid_o <= rx_valid_nxt;
         spi_miso_o <= (state_nxt == ST_ACTIVE) && miso_bit;
      end
   end

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - directed and randomised bench for spi_slave_responder
module tb_spi_slave_responder;

   localparam int H = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sclk, cs_n, mosi, miso;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy;

   int checks = 0;
   int errors = 0;

   // Word-level model: one holding slot, the word currently on MISO, last received word.
   logic       m_full;
   logic [7:0] m_hold, m_cur, m_last_rx;
   logic [7:0] rx_seen[$];

   logic [7:0] got, d;
   int         nw;

   always #5 clk = ~clk;

   spi_slave_responder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk_i      (clk),
      .reset_i    (reset_n),
      .spi_sclk_i (sclk),
      .spi_cs_n_i (cs_n),
      .spi_mosi_i (mosi),
      .spi_miso_o (miso),
      .tx_data_i  (tx_data),
      .tx_valid_i (tx_valid),
      .tx_ready_o (tx_ready),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .busy_o     (busy)
   );

   always @(negedge clk) begin
      if (rx_valid === 1'b1) rx_seen.push_back(rx_data);
   end

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_miso"}, miso, 1'b0);
      chk1({tag, "_tx_ready"}, tx_ready, 1'b1);
      chk1({tag, "_rx_valid"}, rx_valid, 1'b0);
      chk8({tag, "_rx_data"}, rx_data, 8'h00);
      chk1({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic model_reset();
      m_full    = 1'b0;
      m_hold    = 8'h00;
      m_cur     = 8'h00;
      m_last_rx = 8'h00;
   endtask

   task automatic offer(input logic [7:0] w);
      chk1("tx_ready_before_offer", tx_ready, !m_full);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      m_full   = 1'b1;
      m_hold   = w;
      chk1("tx_ready_after_offer", tx_ready, 1'b0);
   endtask

   task automatic cs_low();
      cs_n   = 1'b0;
      m_cur  = m_full ? m_hold : 8'h00;
      m_full = 1'b0;
      repeat (H) @(negedge clk);
      chk1("busy_after_cs_fall", busy, 1'b1);
      chk1("tx_ready_after_cs_fall", tx_ready, 1'b1);
   endtask

   task automatic cs_high();
      repeat (H) @(negedge clk);
      cs_n  = 1'b1;
      m_cur = 8'h00;
      repeat (H) @(negedge clk);
      chk1("busy_after_cs_rise", busy, 1'b0);
      chk1("miso_idle", miso, 1'b0);
   endtask

   // Mode-0 master: MOSI changes with SCLK low, MISO sampled just before SCLK rises.
   task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = w[7-i];
         repeat (H) @(negedge clk);
         r[7-i] = miso;
         sclk = 1'b1;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic full_word(input logic [7:0] w, input string tag);
      logic [7:0] r, exp_miso;
      exp_miso = m_cur;
      rx_seen.delete();
      spi_bits(w, 8, r);
      chk8({tag, "_miso_word"}, r, exp_miso);
      chk8({tag, "_rx_pulses"}, 8'(rx_seen.size()), 8'd1);
      if (rx_seen.size() > 0) chk8({tag, "_rx_word"}, rx_seen[0], w);
      m_last_rx = w;
      m_cur     = m_full ? m_hold : 8'h00;
      m_full    = 1'b0;
      chk1({tag, "_tx_ready_after_word"}, tx_ready, !m_full);
   endtask

   task automatic abort_word(input logic [7:0] w, input int nbits, input string tag);
      logic [7:0] r;
      logic [7:0] mask;
      rx_seen.delete();
      spi_bits(w, nbits, r);
      mask = 8'hFF << (8 - nbits);
      chk8({tag, "_partial_miso"}, r & mask, m_cur & mask);
      cs_high();
      chk8({tag, "_rx_pulses"}, 8'(rx_seen.size()), 8'd0);
      chk8({tag, "_rx_data_kept"}, rx_data, m_last_rx);
   endtask

   initial begin
      model_reset();
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      reset_n  = 1'b0;
      repeat (3) begin
         sclk     = 1'($urandom);
         cs_n     = 1'($urandom);
         mosi     = 1'($urandom);
         tx_valid = 1'($urandom);
         tx_data  = 8'($urandom);
         @(negedge clk);
      end
      check_reset_outputs("reset");
      tx_valid = 1'b0;
      sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (H) @(negedge clk);
      check_reset_outputs("post_reset");

      offer(8'hA5);
      cs_low();
      full_word(8'h3C, "single");
      cs_high();

      offer(8'h81);
      cs_low();
      fork
         full_word(8'h01, "b2b0");
         begin
            repeat (20) @(negedge clk);
            offer(8'h7E);
         end
      join
      full_word(8'hFF, "b2b1");
      cs_high();

      cs_low();
      full_word(8'h55, "underrun");
      cs_high();

      offer(8'h99);
      cs_low();
      abort_word(8'hF0, 5, "abort");
      cs_low();
      full_word(8'h12, "after_abort");
      cs_high();

      offer(8'h6B);
      cs_low();
      spi_bits(8'hE7, 3, got);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_mid_word");
      sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (H) @(negedge clk);
      offer(8'h5A);
      cs_low();
      full_word(8'hC3, "after_reset");
      cs_high();

      for (int it = 0; it < 16; it++) begin
         if (!m_full && ($urandom_range(1, 0) == 1)) offer(8'($urandom));
         cs_low();
         nw = int'($urandom_range(3, 1));
         for (int k = 0; k < nw; k++) begin
            d = 8'($urandom);
            if (!m_full && ($urandom_range(1, 0) == 1)) begin
               fork
                  full_word(d, "rand");
                  begin
                     repeat ($urandom_range(40, 5)) @(negedge clk);
                     offer(8'($urandom));
                  end
               join
            end else begin
               full_word(d, "rand");
            end
         end
         if ($urandom_range(3, 0) == 0) begin
            abort_word(8'($urandom), int'($urandom_range(7, 1)), "rand_abort");
         end else begin
            cs_high();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
